// File: rtl/telemetry_tx.sv
// telemetry_tx: packetizing 8N1 UART transmitter for eBike battery/current/torque telemetry.
module telemetry_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  input  logic        vld,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);
  localparam int BW = $clog2(BAUD_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;
  logic [BW-1:0] cnt, cnt_nxt;
  logic [2:0] bit_cnt, bit_nxt, byte_idx, byte_nxt;
  logic [35:0] shadow, act, act_nxt;
  logic pending, pend_nxt, tx_nxt, tick, start;
  logic [7:0] cur;
  function automatic logic [7:0] byte_sel(input logic [2:0] i, input logic [35:0] a);
    case (i)
      3'd0: byte_sel = 8'hAA;
      3'd1: byte_sel = 8'h55;
      3'd2: byte_sel = {4'h0, a[35:32]};
      3'd3: byte_sel = a[31:24];
      3'd4: byte_sel = {4'h0, a[23:20]};
      3'd5: byte_sel = a[19:12];
      3'd6: byte_sel = {4'h0, a[11:8]};
      default: byte_sel = a[7:0];
    endcase
  endfunction
  assign tick = cnt == BW'(BAUD_DIV - 1);
  assign busy = state != IDLE;
  assign pkt_done = state == STOP && byte_idx == 3'd7 && tick;
  always_comb begin
    state_nxt = state;
    cnt_nxt = (state == IDLE || tick) ? '0 : cnt + 1'b1;
    bit_nxt = bit_cnt;
    byte_nxt = byte_idx;
    act_nxt = act;
    pend_nxt = pending | (vld & busy);
    start = 1'b0;
    case (state)
      IDLE: start = vld | pending;
      START: if (tick) begin
        state_nxt = DATA;
        bit_nxt = 3'd0;
      end
      DATA: if (tick) begin
        bit_nxt = bit_cnt + 3'd1;
        state_nxt = bit_cnt == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        state_nxt = byte_idx == 3'd7 ? IDLE : START;
        byte_nxt = byte_idx == 3'd7 ? byte_idx : byte_idx + 3'd1;
        start = byte_idx == 3'd7 && (pending | vld);
      end
    endcase
    // a vld in the start cycle itself has not reached the shadow yet, so bypass it
    if (start) begin
      state_nxt = START;
      byte_nxt = 3'd0;
      act_nxt = vld ? {batt, curr, torque} : shadow;
      pend_nxt = 1'b0;
    end
  end
  assign cur = byte_sel(byte_nxt, act_nxt);
  assign tx_nxt = state_nxt == START ? 1'b0 : state_nxt == DATA ? cur[bit_nxt] : 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      byte_idx <= '0;
      shadow <= '0;
      act <= '0;
      pending <= 1'b0;
      TX <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      bit_cnt <= bit_nxt;
      byte_idx <= byte_nxt;
      shadow <= vld ? {batt, curr, torque} : shadow;
      act <= act_nxt;
      pending <= pend_nxt;
      TX <= tx_nxt;
    end
endmodule

// File: tb/tb_telemetry_tx.sv
// tb_telemetry_tx: directed scenarios decoding the serial packet at BAUD_DIV=16.
module tb_telemetry_tx;
  logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0;
  logic [11:0] batt = '0, curr = '0, torque = '0;
  logic TX, busy, pkt_done;
  int checks = 0, failures = 0;
  telemetry_tx #(.BAUD_DIV(16)) dut (
    .clk(clk), .rst_n(rst_n), .batt(batt), .curr(curr), .torque(torque),
    .vld(vld), .TX(TX), .busy(busy), .pkt_done(pkt_done)
  );
  always #5 clk = ~clk;
  task automatic pulse_vld(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    batt = b;
    curr = c;
    torque = t;
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
  endtask
  // returns at the middle of byte 7's stop bit; gap = cycles waited for the start bit, -1 on timeout
  task automatic get_packet(output logic [63:0] pkt, output int gap);
    gap = 0;
    pkt = '0;
    while (TX !== 1'b0 && gap < 300) begin
      @(negedge clk);
      gap++;
    end
    if (TX !== 1'b0) begin
      gap = -1;
      return;
    end
    for (int b = 0; b < 8; b++) begin
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        pkt[(7 - b) * 8 + i] = TX;
      end
      repeat (16) @(negedge clk);
      if (b < 7) repeat (8) @(negedge clk);
    end
  endtask
  task automatic test_reset;
    int low;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (TX !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", TX); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (pkt_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", pkt_done); end
    rst_n = 1'b1;
    low = 0;
    repeat (1000) begin
      @(negedge clk);
      if (TX !== 1'b1 || busy !== 1'b0) low++;
    end
    checks++;
    if (low !== 0) begin failures++; $display("FAIL idle_line bad_cycles=%0d exp=0", low); end
  endtask
  task automatic test_single;
    logic [63:0] p;
    int gap;
    pulse_vld(12'hABC, 12'h123, 12'h7F0);
    checks += 2;
    if (TX !== 1'b0) begin failures++; $display("FAIL single_start_tx got=%b exp=0", TX); end
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    get_packet(p, gap);
    checks += 2;
    if (gap !== 0) begin failures++; $display("FAIL single_gap got=%0d exp=0", gap); end
    if (p !== 64'hAA55_0ABC_0123_07F0) begin failures++; $display("FAIL single_pkt got=%h exp=aa550abc012307f0", p); end
    repeat (8) @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_end_busy got=%b exp=0", busy); end
    if (TX !== 1'b1) begin failures++; $display("FAIL single_end_tx got=%b exp=1", TX); end
  endtask
  task automatic test_timing;
    int n, drops;
    pulse_vld(12'h5A5, 12'h0F0, 12'h00F);
    n = 1;
    drops = 0;
    while (pkt_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) drops++;
    end
    checks += 2;
    if (n !== 1280) begin failures++; $display("FAIL done_cycle got=%0d exp=1280", n); end
    if (drops !== 0) begin failures++; $display("FAIL done_busy_drops got=%0d exp=0", drops); end
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL done_busy_fall got=%b exp=0", busy); end
    if (pkt_done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", pkt_done); end
  endtask
  task automatic test_mid_change;
    logic [63:0] p;
    int gap, n;
    pulse_vld(12'hABC, 12'h123, 12'h7F0);
    fork
      get_packet(p, gap);
      begin
        repeat (200) @(negedge clk);
        batt = 12'h000;
        curr = 12'hFFF;
        torque = 12'h000;
      end
    join
    checks += 3;
    if (gap !== 0) begin failures++; $display("FAIL mid_gap got=%0d exp=0", gap); end
    if (p !== 64'hAA55_0ABC_0123_07F0) begin failures++; $display("FAIL mid_pkt got=%h exp=aa550abc012307f0", p); end
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    n = 0;
    while (pkt_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 7) begin failures++; $display("FAIL mid_done_pos got=%0d exp=7", n); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    logic [63:0] p1, p2;
    int g1, g2, low;
    pulse_vld(12'h111, 12'h123, 12'h7F0);
    fork
      get_packet(p1, g1);
      begin
        repeat (300) @(negedge clk);
        pulse_vld(12'h222, 12'h123, 12'h7F0);
        repeat (200) @(negedge clk);
        pulse_vld(12'h333, 12'h123, 12'h7F0);
      end
    join
    get_packet(p2, g2);
    checks += 4;
    if (p1 !== 64'hAA55_0111_0123_07F0) begin failures++; $display("FAIL b2b_pkt1 got=%h exp=aa550111012307f0", p1); end
    if (g2 !== 8) begin failures++; $display("FAIL b2b_gap got=%0d exp=8", g2); end
    if (p2 !== 64'hAA55_0333_0123_07F0) begin failures++; $display("FAIL b2b_pkt2 got=%h exp=aa550333012307f0", p2); end
    if (g1 !== 0) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=0", g1); end
    low = 0;
    repeat (300) begin
      @(negedge clk);
      if (TX !== 1'b1) low++;
    end
    checks += 2;
    if (low !== 0) begin failures++; $display("FAIL b2b_third_pkt low_cycles=%0d exp=0", low); end
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_final_busy got=%b exp=0", busy); end
  endtask
  task automatic test_vld_on_done;
    logic [63:0] p;
    int n, gap;
    pulse_vld(12'h456, 12'h456, 12'h456);
    n = 0;
    while (pkt_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pkt_done !== 1'b1) begin failures++; $display("FAIL ondone_wait got=%b exp=1", pkt_done); end
    pulse_vld(12'h789, 12'h0AB, 12'hFFF);
    checks += 2;
    if (TX !== 1'b0) begin failures++; $display("FAIL ondone_tx got=%b exp=0", TX); end
    if (busy !== 1'b1) begin failures++; $display("FAIL ondone_busy got=%b exp=1", busy); end
    get_packet(p, gap);
    checks += 2;
    if (gap !== 0) begin failures++; $display("FAIL ondone_gap got=%0d exp=0", gap); end
    if (p !== 64'hAA55_0789_00AB_0FFF) begin failures++; $display("FAIL ondone_pkt got=%h exp=aa55078900ab0fff", p); end
    repeat (200) @(negedge clk);
  endtask
  task automatic test_async_reset;
    logic [63:0] p;
    int gap;
    pulse_vld(12'hABC, 12'h123, 12'h7F0);
    repeat (4 * 160 + 40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (TX !== 1'b1) begin failures++; $display("FAIL arst_tx got=%b exp=1", TX); end
    if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (TX !== 1'b1) begin failures++; $display("FAIL arst_idle_tx got=%b exp=1", TX); end
    pulse_vld(12'hC3C, 12'h5A0, 12'h00E);
    get_packet(p, gap);
    checks += 2;
    if (gap !== 0) begin failures++; $display("FAIL arst_gap got=%0d exp=0", gap); end
    if (p !== 64'hAA55_0C3C_05A0_000E) begin failures++; $display("FAIL arst_pkt got=%h exp=aa550c3c05a0000e", p); end
    repeat (20) @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_single;
    test_timing;
    test_mid_change;
    test_back_to_back;
    test_vld_on_done;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
